// File: rtl/cmos_gate_pkg.sv
// Shared types and constants for the CMOS gate checker and gate benches.
// Gate codes, checker state encoding and result widths.
package cmos_gate_pkg;

    typedef enum logic [1:0] {
        GATE_NOR  = 2'd0,
        GATE_NAND = 2'd1,
        GATE_AND  = 2'd2,
        GATE_OR   = 2'd3
    } gate_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int ERR_W = 4;
    localparam int CNT_W = 8;

endpackage

// File: rtl/cmos_gate_checker_if.sv
// Checker-to-gate bundle: run control, gate stimulus/response and results.
// The checker is the master; the gate-side harness is the slave.
interface cmos_gate_checker_if;
    import cmos_gate_pkg::*;

    logic             start;
    logic             dut_a;
    logic             dut_b;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport master (
        input  start,
        input  dut_y,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );

    modport slave (
        output start,
        output dut_y,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational truth table of the 2-input gates under test.
// Shared by every gate bench that needs the expected output.
module gate_ref_model
    import cmos_gate_pkg::*;
(
    input  gate_e i_gate,
    input  logic  i_a,
    input  logic  i_b,
    output logic  o_y
);

    always_comb begin
        o_y = 1'b0;
        unique case (1'b1)
            (i_gate == GATE_NOR):  o_y = ~(i_a | i_b);
            (i_gate == GATE_NAND): o_y = ~(i_a & i_b);
            (i_gate == GATE_AND):  o_y = i_a & i_b;
            (i_gate == GATE_OR):   o_y = i_a | i_b;
            default:               o_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmos_gate_checker.sv
// Sweeps the four input vectors of a 2-input gate, holds each for a
// settle window, samples the output and accumulates mismatch results.
module cmos_gate_checker
    import cmos_gate_pkg::*;
#(
    parameter int GATE          = 0,
    parameter int SETTLE_CYCLES = 2,
    parameter int ROUNDS        = 1
)
(
    input  logic                clk,
    input  logic                rst,
    cmos_gate_checker_if.master bus
);

    localparam gate_e            LP_GATE     = gate_e'(GATE[1:0]);
    localparam logic [CNT_W-1:0] LP_RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LAST_RND = CNT_W'(ROUNDS - 1);
    localparam logic [ERR_W-1:0] LP_ERR_MAX  = '1;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_round;
    logic [1:0]       r_vec;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fail;

    logic             w_exp;
    logic             w_mis;
    logic             w_last;
    logic [1:0]       w_vec_nxt;
    logic [ERR_W-1:0] w_err_nxt;

    gate_ref_model u_ref (
        .i_gate (LP_GATE),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_y    (w_exp)
    );

    // Case-inequality so an X or Z response is a mismatch.
    assign w_mis     = (bus.dut_y !== w_exp);
    assign w_last    = (r_vec == 2'd3) && (r_round == LP_LAST_RND);
    assign w_vec_nxt = r_vec + 2'd1;
    assign w_err_nxt = (w_mis && (r_err != LP_ERR_MAX))
                     ? r_err + ERR_W'(1)
                     : r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_round <= '0;
            r_vec   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= LP_RELOAD;
                        r_round <= '0;
                        r_vec   <= '0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_fail  <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_err <= w_err_nxt;
                        if (w_mis) begin
                            r_fail[r_vec] <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                        end else begin
                            // Vector index wraps 3->0 at the end of a round.
                            r_vec        <= w_vec_nxt;
                            {r_a, r_b}   <= w_vec_nxt;
                            r_cnt        <= LP_RELOAD;
                            if (r_vec == 2'd3) begin
                                r_round <= r_round + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_a     = r_a;
    assign bus.dut_b     = r_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_vec  = r_fail;

endmodule

// File: tb/tb_cmos_gate_checker.sv
// Scoreboard bench: four checker configurations facing behavioural gates
// (ideal, stuck-at-0, unknown on 10, inverted), randomised runs.
module tb_cmos_gate_checker;
    import cmos_gate_pkg::*;

    localparam int NI = 4;
    localparam int GA[NI] = '{0, 0, 0, 1};
    localparam int SA[NI] = '{2, 2, 1, 2};
    localparam int RA[NI] = '{1, 3, 5, 1};

    typedef struct {
        int         done_cyc;
        logic [3:0] err;
        logic [3:0] fv;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic       st[NI];
    int         mode[NI];
    logic       busy_w[NI];
    logic       done_w[NI];
    logic       pass_w[NI];
    logic       a_w[NI];
    logic       b_w[NI];
    logic [3:0] err_w[NI];
    logic [3:0] fv_w[NI];
    logic       prev_done[NI];
    bit         active[NI];
    int         st_cyc[NI];
    exp_t       q[NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural gate seen by the checker: 0 ideal NOR, 1 stuck-at-0,
    // 2 NOR that is unknown for a=1,b=0, 3 NOR with inverted output.
    function automatic logic gate_y(int m, logic a, logic b);
        case (m)
            0:       return ~(a | b);
            1:       return 1'b0;
            2:       return (a && !b) ? 1'bx : ~(a | b);
            default: return a | b;
        endcase
    endfunction

    function automatic logic truth(int g, logic a, logic b);
        case (g)
            0:       return ~(a | b);
            1:       return ~(a & b);
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic exp_t predict(int g, int m, int k);
        exp_t       e;
        int         n;
        logic [1:0] vv;
        n    = 0;
        e.fv = 4'b0000;
        for (int r = 0; r < RA[g]; r++) begin
            for (int v = 0; v < 4; v++) begin
                vv = 2'(v);
                if (gate_y(m, vv[1], vv[0]) !== truth(GA[g], vv[1], vv[0])) begin
                    n++;
                    e.fv[v] = 1'b1;
                end
            end
        end
        e.err      = (n > 15) ? 4'd15 : 4'(n);
        e.pass     = (n == 0);
        e.done_cyc = k + 4 * SA[g] * RA[g];
        return e;
    endfunction

    task automatic chk(string nm, int g, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d",
                     nm, g, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        cmos_gate_checker_if bus ();
        assign bus.start = st[g];
        assign bus.dut_y = gate_y(mode[g], bus.dut_a, bus.dut_b);
        cmos_gate_checker #(
            .GATE          (GA[g]),
            .SETTLE_CYCLES (SA[g]),
            .ROUNDS        (RA[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign pass_w[g] = bus.pass;
        assign a_w[g]    = bus.dut_a;
        assign b_w[g]    = bus.dut_b;
        assign err_w[g]  = bus.err_count;
        assign fv_w[g]   = bus.fail_vec;
    end

    // Monitor: busy window and driven vector each cycle, results on done.
    always @(negedge clk) begin
        exp_t e;
        bit   inwin;
        for (int g = 0; g < NI; g++) begin
            if (active[g]) begin
                inwin = (cyc >= st_cyc[g]) &&
                        (cyc < st_cyc[g] + 4 * SA[g] * RA[g]);
                chk("busy", g, int'(busy_w[g]), int'(inwin));
                if (inwin)
                    chk("vector", g, int'({a_w[g], b_w[g]}),
                        ((cyc - st_cyc[g]) / SA[g]) % 4);
            end
            if (done_w[g] && !prev_done[g]) begin
                if (q[g].size() == 0) begin
                    chk("unexpected_done", g, 1, 0);
                end else begin
                    e = q[g].pop_front();
                    chk("done_edge", g, cyc, e.done_cyc);
                    chk("err_count", g, int'(err_w[g]), int'(e.err));
                    chk("fail_vec", g, int'(fv_w[g]), int'(e.fv));
                    chk("pass", g, int'(pass_w[g]), int'(e.pass));
                    chk("ab_in_done", g, int'({a_w[g], b_w[g]}), 3);
                end
            end
            prev_done[g] = done_w[g];
        end
    end

    task automatic wait_done(int g);
        int i;
        i = 0;
        while (!done_w[g] && i < 4 * SA[g] * RA[g] + 20) begin
            @(negedge clk);
            i++;
        end
        chk("done_timeout", g, int'(done_w[g]), 1);
        @(negedge clk);
    endtask

    task automatic launch(int g, int m);
        int k;
        @(negedge clk);
        mode[g]   = m;
        st[g]     = 1'b1;
        k         = cyc + 1;
        st_cyc[g] = k;
        active[g] = 1'b1;
        q[g].push_back(predict(g, m, k));
        @(negedge clk);
        st[g] = 1'b0;
        chk("clr_err", g, int'(err_w[g]), 0);
        chk("clr_fv", g, int'(fv_w[g]), 0);
    endtask

    task automatic run(int g, int m);
        launch(g, m);
        wait_done(g);
    endtask

    task automatic check_reset(int g);
        chk("rst_busy", g, int'(busy_w[g]), 0);
        chk("rst_done", g, int'(done_w[g]), 0);
        chk("rst_pass", g, int'(pass_w[g]), 0);
        chk("rst_err", g, int'(err_w[g]), 0);
        chk("rst_fv", g, int'(fv_w[g]), 0);
        chk("rst_ab", g, int'({a_w[g], b_w[g]}), 0);
    endtask

    initial begin
        int k;
        int i;
        for (int g = 0; g < NI; g++) begin
            st[g] = 1'b0;
            mode[g] = 0;
            active[g] = 1'b0;
            prev_done[g] = 1'b0;
            st_cyc[g] = 0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) check_reset(g);
        rst = 1'b0;

        run(0, 0);
        run(0, 1);
        run(1, 2);
        run(2, 3);

        // Abort mid-run while vector 10 is driven.
        launch(0, 0);
        i = 0;
        while (!(a_w[0] && !b_w[0]) && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("reach_vec2", 0, int'({a_w[0], b_w[0]}), 2);
        #2;
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            active[g] = 1'b0;
            q[g].delete();
        end
        #1;
        check_reset(0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 0);

        run(3, 0);
        run(3, 0);

        // Start held high: back-to-back runs, done for a single cycle.
        @(negedge clk);
        mode[3]   = 0;
        st[3]     = 1'b1;
        k         = cyc + 1;
        st_cyc[3] = k;
        active[3] = 1'b1;
        q[3].push_back(predict(3, 0, k));
        q[3].push_back(predict(3, 0, k + 9));
        while (cyc < k + 8) @(negedge clk);
        chk("held_done", 3, int'(done_w[3]), 1);
        st_cyc[3] = k + 9;
        @(negedge clk);
        st[3] = 1'b0;
        chk("held_done_1cyc", 3, int'(done_w[3]), 0);
        wait_done(3);

        for (int n = 0; n < 12; n++) begin
            int g;
            g = int'($urandom_range(0, NI - 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(g, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk("queue_empty", g, q[g].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
